// File: rtl/mem_pkg.sv
// Shared memory packet types for memory_model and its clients, plus the
// requester id the arbiter tags each READ with.
package mem_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_type_t;

    typedef struct packed {
        mem_type_t   mtype;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_pkt_t;

    typedef enum logic {
        REQ_IF   = 1'b0,
        REQ_DATA = 1'b1
    } arb_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two core memory ports, the arbiter and memory_model.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
    import mem_pkg::*;

    logic     req0_vld, req0_rdy;
    mem_pkt_t req0_pkt;
    logic     req1_vld, req1_rdy;
    mem_pkt_t req1_pkt;

    logic     rsp0_vld, rsp0_rdy;
    mem_pkt_t rsp0_pkt;
    logic     rsp1_vld, rsp1_rdy;
    mem_pkt_t rsp1_pkt;

    logic     mem_req_vld, mem_req_rdy;
    mem_pkt_t mem_req_pkt;
    logic     mem_rsp_vld, mem_rsp_rdy;
    mem_pkt_t mem_rsp_pkt;

    modport slave (
        input  req0_vld, req0_pkt, req1_vld, req1_pkt,
        output req0_rdy, req1_rdy,
        output rsp0_vld, rsp0_pkt, rsp1_vld, rsp1_pkt,
        input  rsp0_rdy, rsp1_rdy,
        output mem_req_vld, mem_req_pkt, mem_rsp_rdy,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_pkt
    );

    modport master (
        output req0_vld, req0_pkt, req1_vld, req1_pkt,
        input  req0_rdy, req1_rdy,
        input  rsp0_vld, rsp0_pkt, rsp1_vld, rsp1_pkt,
        output rsp0_rdy, rsp1_rdy,
        input  mem_req_vld, mem_req_pkt, mem_rsp_rdy,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_pkt
    );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester ids, one entry per READ in flight.
module mem_arb_id_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  arb_id_t                push_id_i,
    input  logic                   pop_i,
    output arb_id_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    arb_id_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    // Fullness is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing memory_model between instruction fetch (req0) and
// data (req1); READ sources are queued so responses return to their originator.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus,
    output logic           err_unexp_rsp
);

    localparam int unsigned CW = $clog2(MAX_OUTST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    arb_id_t       rr_ptr_q, rr_ptr_d;
    arb_id_t       grant_id, head_id;
    mem_pkt_t      grant_pkt;
    logic          err_q, err_d;
    logic          cand0, cand1, req_xfer;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fifo_push),
        .push_id_i (grant_id),
        .pop_i     (fifo_pop),
        .head_o    (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // A READ is only a candidate while an id slot is free; WRITEs never wait on the FIFO.
    always_comb begin
        cand0 = rst_n & bus.req0_vld & ((bus.req0_pkt.mtype == WRITE) | ~fifo_full);
        cand1 = rst_n & bus.req1_vld & ((bus.req1_pkt.mtype == WRITE) | ~fifo_full);

        if (cand0 && cand1) grant_id = rr_ptr_q;
        else if (cand1)     grant_id = REQ_DATA;
        else                grant_id = REQ_IF;

        grant_pkt       = (grant_id == REQ_DATA) ? bus.req1_pkt : bus.req0_pkt;
        bus.mem_req_vld = cand0 | cand1;
        bus.mem_req_pkt = grant_pkt;
        req_xfer        = (cand0 | cand1) & bus.mem_req_rdy;
        bus.req0_rdy    = req_xfer & (grant_id == REQ_IF);
        bus.req1_rdy    = req_xfer & (grant_id == REQ_DATA);
        fifo_push       = req_xfer & (grant_pkt.mtype == READ);

        rr_ptr_d = rr_ptr_q;
        if (req_xfer) rr_ptr_d = (grant_id == REQ_IF) ? REQ_DATA : REQ_IF;
    end

    // With no READ outstanding a response is swallowed and flagged rather than stalling memory.
    always_comb begin
        bus.rsp0_vld    = 1'b0;
        bus.rsp1_vld    = 1'b0;
        bus.rsp0_pkt    = bus.mem_rsp_pkt;
        bus.rsp1_pkt    = bus.mem_rsp_pkt;
        bus.mem_rsp_rdy = 1'b0;
        fifo_pop        = 1'b0;
        err_d           = err_q;
        if (rst_n) begin
            if (fifo_empty) begin
                bus.mem_rsp_rdy = 1'b1;
                err_d           = err_q | bus.mem_rsp_vld;
            end else if (head_id == REQ_DATA) begin
                bus.rsp1_vld    = bus.mem_rsp_vld;
                bus.mem_rsp_rdy = bus.rsp1_rdy;
                fifo_pop        = bus.mem_rsp_vld & bus.rsp1_rdy;
            end else begin
                bus.rsp0_vld    = bus.mem_rsp_vld;
                bus.mem_rsp_rdy = bus.rsp0_rdy;
                fifo_pop        = bus.mem_rsp_vld & bus.rsp0_rdy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= REQ_IF;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign err_unexp_rsp = err_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= MAX_CNT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MAX_OUTST=4; the bench plays memory_model by hand.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_unexp_rsp;
    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_OUTST (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_pkt_t pkt(input mem_type_t t, input logic [31:0] a, input logic [31:0] d);
        mem_pkt_t p;
        p.mtype = t;
        p.addr  = a;
        p.data  = d;
        return p;
    endfunction

    task automatic idle();
        bus.req0_vld    = 1'b0;
        bus.req0_pkt    = '0;
        bus.req1_vld    = 1'b0;
        bus.req1_pkt    = '0;
        bus.rsp0_rdy    = 1'b1;
        bus.rsp1_rdy    = 1'b1;
        bus.mem_req_rdy = 1'b1;
        bus.mem_rsp_vld = 1'b0;
        bus.mem_rsp_pkt = '0;
    endtask

    // Leaves the bench at a negedge with rst_n just released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held 3 cycles with every valid asserted
        idle();
        rst_n           = 1'b0;
        bus.req0_vld    = 1'b1;
        bus.req0_pkt    = pkt(READ, 32'h0, 32'h0);
        bus.req1_vld    = 1'b1;
        bus.req1_pkt    = pkt(READ, 32'h20, 32'h0);
        bus.mem_rsp_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("reset_outs_%0d", i),
                  {bus.req0_rdy, bus.req1_rdy, bus.mem_req_vld, bus.mem_rsp_rdy,
                   bus.rsp0_vld, bus.rsp1_vld, err_unexp_rsp}, 7'b0);
        end
        @(negedge clk);
        rst_n           = 1'b1;
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("post_reset_grant", {bus.req1_rdy, bus.req0_rdy}, 2'b01);
        check("post_reset_addr", bus.mem_req_pkt.addr, 32'h0);
        check("post_reset_err", err_unexp_rsp, 1'b0);

        // Both requesters always valid: grants alternate starting with req0
        do_reset();
        bus.req0_vld = 1'b1;
        bus.req0_pkt = pkt(READ, 32'h10, 32'h0);
        bus.req1_vld = 1'b1;
        bus.req1_pkt = pkt(READ, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_grant_%0d", i), {bus.req1_rdy, bus.req0_rdy},
                  (i % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr_addr_%0d", i), bus.mem_req_pkt.addr,
                  (i % 2 == 1) ? 32'h20 : 32'h10);
            @(negedge clk);
        end
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        #1;
        check("rr_count_full", dut.u_fifo.count_o, 3'd4);
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_pkt = pkt(READ, 32'h10, 32'hAAAA_0000);
        #1;
        check("rsp_a_route", {bus.rsp1_vld, bus.rsp0_vld, bus.mem_rsp_rdy}, 3'b011);
        check("rsp_a_data", bus.rsp0_pkt.data, 32'hAAAA_0000);
        @(negedge clk);
        bus.mem_rsp_pkt = pkt(READ, 32'h20, 32'hBBBB_0000);
        #1;
        check("rsp_b_route", {bus.rsp1_vld, bus.rsp0_vld, bus.mem_rsp_rdy}, 3'b101);
        check("rsp_b_data", bus.rsp1_pkt.data, 32'hBBBB_0000);
        @(negedge clk);
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("rr_count_after_two_pops", dut.u_fifo.count_o, 3'd2);

        // Outstanding limit: 5th READ held, WRITE from req1 still passes
        do_reset();
        bus.req0_vld = 1'b1;
        bus.req0_pkt = pkt(READ, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fill_rdy_%0d", i), bus.req0_rdy, 1'b1);
            @(negedge clk);
        end
        bus.req1_vld = 1'b1;
        bus.req1_pkt = pkt(WRITE, 32'h4, 32'hC0FF_EE69);
        #1;
        check("full_grants", {bus.req1_rdy, bus.req0_rdy}, 2'b10);
        check("full_write_pkt", bus.mem_req_pkt, pkt(WRITE, 32'h4, 32'hC0FF_EE69));
        @(negedge clk);
        bus.req1_vld    = 1'b0;
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_pkt = pkt(READ, 32'h40, 32'h1111);
        #1;
        check("full_write_no_push", dut.u_fifo.count_o, 3'd4);
        check("pop_no_free_slot", {bus.req0_rdy, bus.mem_req_vld}, 2'b00);
        check("pop_rsp0", {bus.rsp0_vld, bus.mem_rsp_rdy}, 2'b11);
        @(negedge clk);
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("after_pop_rdy", bus.req0_rdy, 1'b1);
        @(negedge clk);
        bus.req0_vld = 1'b0;
        #1;
        check("refill_count", dut.u_fifo.count_o, 3'd4);

        // Stalled response for req1 does not block req0 requests
        do_reset();
        bus.req1_vld = 1'b1;
        bus.req1_pkt = pkt(READ, 32'h50, 32'h0);
        #1;
        check("stall_req1_grant", bus.req1_rdy, 1'b1);
        @(negedge clk);
        bus.req1_vld    = 1'b0;
        bus.rsp1_rdy    = 1'b0;
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_pkt = pkt(READ, 32'h50, 32'h1234);
        bus.req0_vld    = 1'b1;
        bus.req0_pkt    = pkt(READ, 32'h30, 32'h0);
        #1;
        check("stall_hold", {bus.rsp1_vld, bus.rsp0_vld, bus.mem_rsp_rdy}, 3'b100);
        check("stall_req0_grant", bus.req0_rdy, 1'b1);
        @(negedge clk);
        bus.req0_vld = 1'b0;
        #1;
        check("stall_count", dut.u_fifo.count_o, 3'd2);
        check("stall_still_held", bus.mem_rsp_rdy, 1'b0);
        bus.rsp1_rdy = 1'b1;
        #1;
        check("stall_release", {bus.rsp1_vld, bus.mem_rsp_rdy}, 2'b11);
        @(negedge clk);
        #1;
        check("stall_next_head", {bus.rsp1_vld, bus.rsp0_vld}, 2'b01);
        check("stall_count_after", dut.u_fifo.count_o, 3'd1);
        @(negedge clk);
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("stall_drained", dut.u_fifo.count_o, 3'd0);

        // Simultaneous push and pop at count=2
        do_reset();
        bus.req0_vld = 1'b1;
        bus.req0_pkt = pkt(READ, 32'h60, 32'h0);
        @(negedge clk);
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b1;
        bus.req1_pkt = pkt(READ, 32'h70, 32'h0);
        @(negedge clk);
        bus.req1_vld = 1'b0;
        #1;
        check("pp_count_pre", dut.u_fifo.count_o, 3'd2);
        bus.req0_vld    = 1'b1;
        bus.req0_pkt    = pkt(READ, 32'h64, 32'h0);
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_pkt = pkt(READ, 32'h60, 32'h600D);
        #1;
        check("pp_both", {bus.req0_rdy, bus.rsp0_vld, bus.rsp1_vld}, 3'b110);
        @(negedge clk);
        bus.req0_vld = 1'b0;
        #1;
        check("pp_count_post", dut.u_fifo.count_o, 3'd2);
        check("pp_order_1", {bus.rsp1_vld, bus.rsp0_vld}, 2'b10);
        @(negedge clk);
        #1;
        check("pp_order_0", {bus.rsp1_vld, bus.rsp0_vld}, 2'b01);
        @(negedge clk);
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("pp_drained", dut.u_fifo.count_o, 3'd0);
        check("pp_no_err", err_unexp_rsp, 1'b0);

        // Unexpected response with an empty FIFO: dropped and flagged until reset
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_pkt = pkt(READ, 32'h0, 32'hDEAD);
        #1;
        check("unexp_drop", {bus.mem_rsp_rdy, bus.rsp0_vld, bus.rsp1_vld, err_unexp_rsp}, 4'b1000);
        @(negedge clk);
        bus.mem_rsp_vld = 1'b0;
        #1;
        check("unexp_err_set", err_unexp_rsp, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("unexp_err_sticky", err_unexp_rsp, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("unexp_err_cleared", err_unexp_rsp, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
